trap_seq: RTL and testbench
===========================

Name: trap_seq

Overview:
Sequencer for trap entry and trap return around the jump/trap-target unit.
- Synchronizes and masks the external interrupt line and presents `external_int` to the jump unit.
- On `trap_taken`, captures the trap context, owns mstatus MIE/MPIE stacking, and writes mepc/mcause/mtval over successive cycles through the single CSR write port.
- Stalls the pipeline during the sequence, then issues a one-cycle `pipe_flush`.

Parameters:
- SYNC_STAGES, 2, flops in the irq_ext synchronizer (min 2).
- MEPC_ADDR, 12'h341, CSR address written with the trap pc.
- MCAUSE_ADDR, 12'h342, CSR address written with the cause.
- MTVAL_ADDR, 12'h343, CSR address written with the trap value (only when MTVAL_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- irq_ext  in  1  asynchronous level external interrupt request
- meie  in  1  mie.MEIE enable bit from CSR file
- trap_taken  in  1  from jump unit; trap entry or return this cycle
- trap_return  in  1  mret decoded this cycle
- trap_src  in  5  from jump unit; bit4 = interrupt, [3:0] = code
- trap_pc  in  32  pc of trapping instruction
- trap_val  in  32  faulting address/instruction for mtval
- mstatus_we  in  1  software write to mstatus
- mstatus_wdata  in  32  software mstatus data (bit3 = MIE, bit7 = MPIE)
- external_int  out  1  masked, synchronized interrupt to jump unit
- pipe_stall  out  1  hold fetch/decode/execute
- pipe_flush  out  1  kill younger instructions, one cycle
- csr_we  out  1  CSR write strobe
- csr_waddr  out  12  CSR write address
- csr_wdata  out  32  CSR write data
- mstatus_mie  out  1  global interrupt enable
- mstatus_mpie  out  1  previous interrupt enable
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock `clk`. Reset is asynchronous, active-low (`rst_n`).
- Reset values:
  - state = IDLE.
  - All outputs 0, including mstatus_mie = 0 and mstatus_mpie = 0.
  - Synchronizer flops cleared.
  - Reset mid-sequence aborts immediately; no further CSR writes.
- Interrupt path: irq_ext passes through SYNC_STAGES flops. external_int = irq_sync & meie & mstatus_mie & (state == IDLE).
- States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL (MTVAL_EN only), FLUSH.
- IDLE:
  - trap_taken & !trap_return (entry):
    - Latch trap_pc, trap_src, trap_val.
    - mpie <= mie; mie <= 0.
    - Go to W_MEPC.
  - trap_taken & trap_return (return):
    - mie <= mpie; mpie <= 1.
    - Go to FLUSH.
  - No trap, mstatus_we = 1: mie <= wdata[3]; mpie <= wdata[7].
  - Priority: trap entry > trap return > mstatus_we.
- W_MEPC: csr_we = 1, addr = MEPC_ADDR, data = latched pc. Next W_MCAUSE.
- W_MCAUSE:
  - csr_we = 1, addr = MCAUSE_ADDR.
  - data = {src[4], 27'b0, src[3:0]}.
  - Next W_MTVAL if MTVAL_EN, else FLUSH.
- W_MTVAL: csr_we = 1, addr = MTVAL_ADDR, data = latched val. Next FLUSH.
- FLUSH: pipe_flush = 1 for exactly one cycle. Next IDLE.
- pipe_stall = 1 in every state except IDLE and FLUSH.
- csr_we = 0 in IDLE/FLUSH; csr_waddr and csr_wdata = 0 when csr_we = 0.
- While busy:
  - trap_taken, trap_return and mstatus_we are ignored, with no state change.
  - external_int is held 0.
- Latency (entry at cycle T): mepc write T+1, mcause T+2, mtval T+3, flush T+4, IDLE T+5. Without MTVAL_EN: flush T+3, IDLE T+4.
- Latency (return at cycle T): flush T+1, IDLE T+2.
- All outputs are registered or decoded from state only. There is no combinational path from any input to csr_*, pipe_*, or busy.
- external_int is the only output with combinational dependence on an input (meie).

Optional Feature:
TRAP_SEQ_MTVAL_EN
- Defined: W_MTVAL state present; mtval written with latched trap_val; entry sequence is 5 cycles.
- Undefined: W_MTVAL state removed; trap_val ignored; W_MCAUSE goes directly to FLUSH; entry sequence is 4 cycles.

Test Plan:
1. Reset, then trap_taken = 1, trap_src = 5'h02, trap_pc = 32'h0000_0104, trap_val = 32'h0000_0013 → writes (0x341, 0x104), (0x342, 0x2), (0x343, 0x13) on T+1..T+3. pipe_stall high T+1..T+3. pipe_flush high only at T+4.
2. mstatus_we with wdata = 32'h8, meie = 1, irq_ext = 1 → external_int rises after SYNC_STAGES cycles. Trap entry with trap_src = 5'h1B → mcause = 32'h8000_000B, mie = 0, mpie = 1, external_int drops.
3. After test 2, trap_taken = 1 with trap_return = 1 → mie = 1, mpie = 1, flush at T+1, no csr_we.
4. trap_taken = 1 and mstatus_we = 1 (wdata = 0x88) in the same cycle → trap wins; mie = 0; mstatus write discarded.
5. Second trap_taken pulse at T+2 → ignored; exactly 3 CSR writes occur, then one flush.
6. rst_n low at T+2 → immediate IDLE, csr_we = 0, no flush. With TRAP_SEQ_MTVAL_EN undefined, repeat test 1 → only 2 CSR writes, flush at T+3.

Source files
------------

// File: rtl/trap_seq.sv
// trap_seq: trap entry / trap return sequencer around the jump unit.
//
// Synchronizes and masks the external interrupt, owns mstatus MIE/MPIE
// stacking, and on trap entry writes mepc, mcause and (optionally) mtval
// through the single CSR write port on successive cycles. The pipeline is
// stalled while those writes happen, then flushed for exactly one cycle.
//
// Build option: define TRAP_SEQ_MTVAL_EN to add the W_MTVAL state and write
// mtval with the latched trap value. Without it the entry sequence skips
// straight from W_MCAUSE to FLUSH and trap_val is ignored.
//
// Handshake: there is no valid/ready pair here. trap_taken is a single-cycle
// request that is only accepted while busy = 0; any request seen while busy
// is dropped, and the jump unit is expected to be held by pipe_stall.
//
// Output timing: csr_*, pipe_* and busy are decoded from state and
// registered context only. external_int is the one output with a
// combinational input term (meie).

module trap_seq #(
  parameter int          SYNC_STAGES = 2,        // minimum 2
  parameter logic [11:0] MEPC_ADDR   = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR = 12'h342,
  parameter logic [11:0] MTVAL_ADDR  = 12'h343
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irq_ext,
  input  logic        meie,
  input  logic        trap_taken,
  input  logic        trap_return,
  input  logic [4:0]  trap_src,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mstatus_we,
  input  logic [31:0] mstatus_wdata,
  output logic        external_int,
  output logic        pipe_stall,
  output logic        pipe_flush,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        mstatus_mie,
  output logic        mstatus_mpie,
  output logic        busy
);

  // FSM encoding
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_W_MEPC   = 3'd1;
  localparam logic [2:0] S_W_MCAUSE = 3'd2;
  localparam logic [2:0] S_W_MTVAL  = 3'd3;
  localparam logic [2:0] S_FLUSH    = 3'd4;

  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [SYNC_STAGES-1:0] irq_sync;
  logic [31:0]            pc_q;
  logic [4:0]             src_q;
  logic                   is_idle;
  logic                   do_entry;
  logic                   do_return;
  logic                   do_sw_write;

  // Only MIE (bit 3) and MPIE (bit 7) of the software write are stored.
  logic unused_mstatus_bits;
  assign unused_mstatus_bits = ^{mstatus_wdata[31:8], mstatus_wdata[6:4],
                                 mstatus_wdata[2:0]};

`ifdef TRAP_SEQ_MTVAL_EN
  logic [31:0] val_q;
`else
  // Without the mtval write there is nothing to do with the trap value.
  logic unused_trap_val;
  assign unused_trap_val = ^trap_val;
`endif

  // Requests are only honoured in IDLE; entry beats return beats SW write.
  assign is_idle     = (state == S_IDLE);
  assign do_entry    = is_idle & trap_taken & ~trap_return;
  assign do_return   = is_idle & trap_taken &  trap_return;
  assign do_sw_write = is_idle & ~trap_taken & mstatus_we;

  // Interrupt request synchronizer; cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_sync <= '0;
    end else begin
      irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq_ext};
    end
  end

  // Masked interrupt to the jump unit; suppressed while a sequence runs.
  assign external_int = irq_sync[SYNC_STAGES-1] & meie & mstatus_mie & is_idle;

  // Next-state logic for the trap sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (do_entry) begin
          state_nxt = S_W_MEPC;
        end else if (do_return) begin
          state_nxt = S_FLUSH;
        end
      end
      S_W_MEPC:   state_nxt = S_W_MCAUSE;
`ifdef TRAP_SEQ_MTVAL_EN
      S_W_MCAUSE: state_nxt = S_W_MTVAL;
      S_W_MTVAL:  state_nxt = S_FLUSH;
`else
      S_W_MCAUSE: state_nxt = S_FLUSH;
`endif
      S_FLUSH:    state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Trap context capture on entry; held stable for the whole sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      src_q <= '0;
    end else if (do_entry) begin
      pc_q  <= trap_pc;
      src_q <= trap_src;
    end
  end

`ifdef TRAP_SEQ_MTVAL_EN
  // Trap value capture, only needed when mtval is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
    end else if (do_entry) begin
      val_q <= trap_val;
    end
  end
`endif

  // mstatus MIE/MPIE stacking: entry pushes, return pops, SW write loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (do_entry) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (do_return) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (do_sw_write) begin
      mstatus_mie  <= mstatus_wdata[3];
      mstatus_mpie <= mstatus_wdata[7];
    end
  end

  // CSR write port driven purely from state and latched context.
  always_comb begin
    csr_we    = 1'b0;
    csr_waddr = 12'h000;
    csr_wdata = 32'h0000_0000;
    case (state)
      S_W_MEPC: begin
        csr_we    = 1'b1;
        csr_waddr = MEPC_ADDR;
        csr_wdata = pc_q;
      end
      S_W_MCAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = MCAUSE_ADDR;
        csr_wdata = {src_q[4], 27'b0, src_q[3:0]};
      end
`ifdef TRAP_SEQ_MTVAL_EN
      S_W_MTVAL: begin
        csr_we    = 1'b1;
        csr_waddr = MTVAL_ADDR;
        csr_wdata = val_q;
      end
`endif
      default: begin
        csr_we    = 1'b0;
        csr_waddr = 12'h000;
        csr_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Pipeline controls: stall during CSR writes, flush once at the end.
  always_comb begin
    pipe_stall = (state == S_W_MEPC) | (state == S_W_MCAUSE) | (state == S_W_MTVAL);
    pipe_flush = (state == S_FLUSH);
    busy       = ~is_idle;
  end

endmodule

// File: tb/tb_trap_seq.sv
// tb_trap_seq: directed bench for trap_seq.
// CSR writes are checked by a scoreboard fed from an expected queue; stall,
// flush, busy and mstatus bits are checked cycle by cycle.
// Expectations follow TRAP_SEQ_MTVAL_EN when it is defined for the build.

module tb_trap_seq;

`ifdef TRAP_SEQ_MTVAL_EN
  localparam int NW = 3;
`else
  localparam int NW = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        irq_ext;
  logic        meie;
  logic        trap_taken;
  logic        trap_return;
  logic [4:0]  trap_src;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        mstatus_we;
  logic [31:0] mstatus_wdata;
  logic        external_int;
  logic        pipe_stall;
  logic        pipe_flush;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        busy;

  int checks = 0;
  int failures = 0;

  // Expected CSR writes: {addr, data}
  logic [43:0] exp_q[$];

  trap_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_ext      (irq_ext),
    .meie         (meie),
    .trap_taken   (trap_taken),
    .trap_return  (trap_return),
    .trap_src     (trap_src),
    .trap_pc      (trap_pc),
    .trap_val     (trap_val),
    .mstatus_we   (mstatus_we),
    .mstatus_wdata(mstatus_wdata),
    .external_int (external_int),
    .pipe_stall   (pipe_stall),
    .pipe_flush   (pipe_flush),
    .csr_we       (csr_we),
    .csr_waddr    (csr_waddr),
    .csr_wdata    (csr_wdata),
    .mstatus_mie  (mstatus_mie),
    .mstatus_mpie (mstatus_mpie),
    .busy         (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every CSR write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && csr_we) begin
      if (exp_q.size() == 0) begin
        check("csr_extra_write", {20'h0, csr_waddr, csr_wdata}, 64'h0);
      end else begin
        check("csr_write", {20'h0, csr_waddr, csr_wdata}, {20'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [31:0] pc, input logic [4:0] src, input logic [31:0] val);
    exp_q.push_back({12'h341, pc});
    exp_q.push_back({12'h342, src[4], 27'b0, src[3:0]});
`ifdef TRAP_SEQ_MTVAL_EN
    exp_q.push_back({12'h343, val});
`else
    if (val != val) exp_q.push_back(44'h0);
`endif
  endtask

  task automatic drive_entry(input logic [31:0] pc, input logic [4:0] src, input logic [31:0] val);
    trap_taken  = 1'b1;
    trap_return = 1'b0;
    trap_pc     = pc;
    trap_src    = src;
    trap_val    = val;
  endtask

  // Walks an entry sequence starting in the cycle trap_taken is driven.
  // A new trap_taken pulse is driven during cycle T+pulse_at (0 = none).
  task automatic expect_seq(input string tag, input int pulse_at);
    for (int i = 1; i <= NW; i++) begin
      tick();
      check({tag, "_stall"}, pipe_stall, 1'b1);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_noflush"}, pipe_flush, 1'b0);
      check({tag, "_extint_masked"}, external_int, 1'b0);
      trap_taken  = (i == pulse_at);
      trap_pc     = 32'h0000_DEAD;
      trap_src    = 5'h1F;
      mstatus_we  = 1'b0;
    end
    tick();
    trap_taken = 1'b0;
    check({tag, "_flush"}, pipe_flush, 1'b1);
    check({tag, "_flush_stall"}, pipe_stall, 1'b0);
    check({tag, "_flush_csr_we"}, csr_we, 1'b0);
    tick();
    check({tag, "_idle_flush"}, pipe_flush, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; irq_ext = 1'b0; meie = 1'b0;
    trap_taken = 1'b0; trap_return = 1'b0; trap_src = '0;
    trap_pc = '0; trap_val = '0; mstatus_we = 1'b0; mstatus_wdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_csr_we", csr_we, 1'b0);
    check("rst_stall", pipe_stall, 1'b0);
    check("rst_flush", pipe_flush, 1'b0);
    check("rst_mie", mstatus_mie, 1'b0);
    check("rst_mpie", mstatus_mpie, 1'b0);
    check("rst_extint", external_int, 1'b0);

    // Test 1: exception entry
    push_entry(32'h0000_0104, 5'h02, 32'h0000_0013);
    drive_entry(32'h0000_0104, 5'h02, 32'h0000_0013);
    expect_seq("t1", 0);
    check("t1_mie", mstatus_mie, 1'b0);
    check("t1_mpie", mstatus_mpie, 1'b0);

    // Test 2: enable interrupts, then take an interrupt trap
    mstatus_we = 1'b1; mstatus_wdata = 32'h8; meie = 1'b1; irq_ext = 1'b1;
    tick();
    mstatus_we = 1'b0;
    check("t2_mie_set", mstatus_mie, 1'b1);
    check("t2_mpie_clr", mstatus_mpie, 1'b0);
    check("t2_extint_sync1", external_int, 1'b0);
    tick();
    check("t2_extint_sync2", external_int, 1'b1);
    push_entry(32'h0000_0200, 5'h1B, 32'h0000_0000);
    drive_entry(32'h0000_0200, 5'h1B, 32'h0000_0000);
    expect_seq("t2", 0);
    check("t2_mie", mstatus_mie, 1'b0);
    check("t2_mpie", mstatus_mpie, 1'b1);
    check("t2_extint_drop", external_int, 1'b0);

    // Test 3: mret
    trap_taken = 1'b1; trap_return = 1'b1;
    tick();
    trap_taken = 1'b0; trap_return = 1'b0;
    check("t3_flush", pipe_flush, 1'b1);
    check("t3_csr_we", csr_we, 1'b0);
    check("t3_stall", pipe_stall, 1'b0);
    check("t3_mie", mstatus_mie, 1'b1);
    check("t3_mpie", mstatus_mpie, 1'b1);
    tick();
    check("t3_idle_flush", pipe_flush, 1'b0);
    check("t3_idle_busy", busy, 1'b0);
    check("t3_extint", external_int, 1'b1);

    // Test 4: trap entry beats a same-cycle mstatus write
    push_entry(32'h0000_0300, 5'h05, 32'h0000_0044);
    drive_entry(32'h0000_0300, 5'h05, 32'h0000_0044);
    mstatus_we = 1'b1; mstatus_wdata = 32'h88;
    expect_seq("t4", 0);
    check("t4_mie", mstatus_mie, 1'b0);
    check("t4_mpie", mstatus_mpie, 1'b1);

    // Test 5: a second trap pulse mid-sequence is ignored
    irq_ext = 1'b0;
    push_entry(32'h0000_0500, 5'h07, 32'h0000_0055);
    drive_entry(32'h0000_0500, 5'h07, 32'h0000_0055);
    expect_seq("t5", 2);

    // Test 6: reset mid-sequence aborts with no further writes or flush
    exp_q.push_back({12'h341, 32'h0000_0400});
    drive_entry(32'h0000_0400, 5'h03, 32'h0000_0077);
    tick();
    trap_taken = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 1'b0);
    check("t6_csr_we", csr_we, 1'b0);
    check("t6_stall", pipe_stall, 1'b0);
    check("t6_flush", pipe_flush, 1'b0);
    check("t6_mie", mstatus_mie, 1'b0);
    check("t6_mpie", mstatus_mpie, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t6_rst_noflush", pipe_flush, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_post_noflush", pipe_flush, 1'b0);
      check("t6_post_busy", busy, 1'b0);
    end
    check("t6_q_empty", exp_q.size(), 0);

    // Repeat test 1 after the aborted sequence
    push_entry(32'h0000_0104, 5'h02, 32'h0000_0013);
    drive_entry(32'h0000_0104, 5'h02, 32'h0000_0013);
    expect_seq("t6r", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
